led_seq_ctrl: RTL and testbench

//   Memory-mapped sequencer for the board LED output register. The CPU configures

---
 rtl/led_seq_ctrl.sv | 135 +++++++++++++
 tb/tb_led_seq_ctrl.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/led_seq_ctrl.sv
// led_seq_ctrl: register-mapped LED sequencer (off / static / blink / rotate).
// The CPU programs CTRL, PATTERN and PERIOD. The block drives a registered LED word
// and a one-cycle write strobe into the LED driver register.
module led_seq_ctrl #(
   parameter int                    PRESCALE_W     = 24,
   parameter logic [PRESCALE_W-1:0] DEFAULT_PERIOD = 24'd2500000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [1:0]  Addr,
   input  logic [31:0] DataIn,
   input  logic        WE,
   output logic [31:0] DataOut,
   output logic [31:0] LedData,
   output logic        LedWE
);

   localparam logic [1:0] MODE_OFF    = 2'd0;
   localparam logic [1:0] MODE_STATIC = 2'd1;
   localparam logic [1:0] MODE_BLINK  = 2'd2;
   localparam logic [1:0] MODE_ROTATE = 2'd3;

   localparam logic [1:0] A_CTRL    = 2'd0;
   localparam logic [1:0] A_PATTERN = 2'd1;
   localparam logic [1:0] A_PERIOD  = 2'd2;
   localparam logic [1:0] A_CUR     = 2'd3;

   localparam logic [PRESCALE_W-1:0] CNT_ONE = {{(PRESCALE_W-1){1'b0}}, 1'b1};

   logic [1:0]            mode_q, mode_d;
   logic                  dir_q, dir_d;
   logic [31:0]           pattern_q, pattern_d;
   logic [PRESCALE_W-1:0] period_q, period_d;
   logic [PRESCALE_W-1:0] cnt_q, cnt_d;
   logic                  phase_q, phase_d;
   logic [31:0]           led_q, led_d;
   logic                  led_we_q, led_we_d;

   logic tick;
   logic wr_cfg;

   assign tick   = (cnt_q == period_q);
   // Address 3 is the read-only LED mirror: a write there neither restarts nor strobes.
   assign wr_cfg = WE && (Addr != A_CUR);

   // Next-state: register writes, prescaler, and LED update events.
   always_comb begin
      mode_d    = mode_q;
      dir_d     = dir_q;
      pattern_d = pattern_q;
      period_d  = period_q;
      phase_d   = phase_q;
      led_d     = led_q;
      led_we_d  = 1'b0;
      cnt_d     = tick ? '0 : cnt_q + CNT_ONE;

      if (WE) begin
         case (Addr)
            A_CTRL: begin
               mode_d = DataIn[1:0];
               dir_d  = DataIn[2];
            end
            A_PATTERN: pattern_d = DataIn;
            A_PERIOD:  period_d  = DataIn[PRESCALE_W-1:0];
            default: ;
         endcase
      end

      if (wr_cfg) begin
         // A config write restarts the step timer; any coincident tick is dropped.
         cnt_d   = '0;
         phase_d = 1'b1;
         if (Addr != A_PERIOD) begin
            // Entry value is taken from the freshly written register contents.
            led_d    = (mode_d == MODE_OFF) ? 32'd0 : pattern_d;
            led_we_d = 1'b1;
         end
      end else if (tick) begin
         case (mode_q)
            MODE_BLINK: begin
               phase_d  = ~phase_q;
               led_d    = phase_d ? pattern_q : 32'd0;
               led_we_d = 1'b1;
            end
            MODE_ROTATE: begin
               led_d    = dir_q ? {led_q[0], led_q[31:1]} : {led_q[30:0], led_q[31]};
               led_we_d = 1'b1;
            end
            default: ;  // OFF and STATIC ignore ticks
         endcase
      end
   end

   // State registers with synchronous reset; reset beats any event in its cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         mode_q    <= MODE_OFF;
         dir_q     <= 1'b0;
         pattern_q <= '0;
         period_q  <= DEFAULT_PERIOD;
         cnt_q     <= '0;
         phase_q   <= 1'b0;
         led_q     <= '0;
         led_we_q  <= 1'b0;
      end else begin
         mode_q    <= mode_d;
         dir_q     <= dir_d;
         pattern_q <= pattern_d;
         period_q  <= period_d;
         cnt_q     <= cnt_d;
         phase_q   <= phase_d;
         led_q     <= led_d;
         led_we_q  <= led_we_d;
      end
   end

   // Combinational register readback.
   always_comb begin
      DataOut = 32'd0;
      case (Addr)
         A_CTRL:    DataOut = {29'd0, dir_q, mode_q};
         A_PATTERN: DataOut = pattern_q;
         A_PERIOD:  DataOut = {{(32-PRESCALE_W){1'b0}}, period_q};
         default:   DataOut = led_q;
      endcase
   end

   assign LedData = led_q;
   assign LedWE   = led_we_q;

   // MODE_STATIC is only referenced implicitly through the default branch above.
   logic unused_static;
   assign unused_static = (mode_q == MODE_STATIC);

endmodule

// File: tb/tb_led_seq_ctrl.sv
// tb_led_seq_ctrl: directed stimulus with a strobe scoreboard for led_seq_ctrl.
// Expected LED words are queued as stimulus is issued. The monitor pops one entry
// on every observed LedWE strobe.
module tb_led_seq_ctrl;

   logic        clk;
   logic        reset;
   logic [1:0]  Addr;
   logic [31:0] DataIn;
   logic        WE;
   logic [31:0] DataOut;
   logic [31:0] LedData;
   logic        LedWE;

   int n_chk  = 0;
   int n_fail = 0;
   logic [31:0] exp_q[$];

   led_seq_ctrl dut (
      .clk    (clk),
      .reset  (reset),
      .Addr   (Addr),
      .DataIn (DataIn),
      .WE     (WE),
      .DataOut(DataOut),
      .LedData(LedData),
      .LedWE  (LedWE)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Drive one write for exactly one clock; returns at the following negedge.
   task automatic wr(input logic [1:0] a, input logic [31:0] d);
      Addr = a; DataIn = d; WE = 1'b1;
      @(negedge clk);
      WE = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic rd(input string name, input logic [1:0] a, input logic [31:0] exp);
      Addr = a;
      #1;
      chk(name, DataOut, exp);
   endtask

   // Monitor: every strobe must match the oldest queued expectation.
   initial begin
      forever begin
         @(negedge clk);
         if (LedWE === 1'b1) begin
            if (exp_q.size() == 0) begin
               n_chk++;
               n_fail++;
               $display("FAIL unexpected_strobe: got LedData %h expected no strobe", LedData);
            end else begin
               chk("strobe_data", LedData, exp_q.pop_front());
            end
         end
      end
   end

   initial begin
      reset = 1'b1; WE = 1'b0; Addr = 2'd0; DataIn = 32'd0;

      // 1: reset held for two edges
      idle(2);
      chk("rst_led", LedData, 32'd0);
      chk("rst_we", {31'd0, LedWE}, 32'd0);
      rd("rst_period", 2'd2, 32'd2500000);
      rd("rst_ctrl", 2'd0, 32'd0);
      rd("rst_pattern", 2'd1, 32'd0);
      @(negedge clk);
      reset = 1'b0;
      idle(2);
      chk("no_exit_strobe", {31'd0, LedWE}, 32'd0);

      // Write to CUR is ignored entirely
      wr(2'd3, 32'hFFFF_FFFF);
      chk("cur_wr_no_strobe", {31'd0, LedWE}, 32'd0);
      rd("cur_wr_ignored", 2'd3, 32'd0);

      // 2: STATIC
      exp_q.push_back(32'd0);
      wr(2'd1, 32'h0000_00A5);
      chk("pat_wr_latency", {31'd0, LedWE}, 32'd1);
      exp_q.push_back(32'h0000_00A5);
      wr(2'd0, 32'd1);
      chk("static_latency", {31'd0, LedWE}, 32'd1);
      chk("static_data", LedData, 32'h0000_00A5);
      rd("ctrl_readback", 2'd0, 32'd1);
      idle(20);
      chk("static_hold", LedData, 32'h0000_00A5);

      // 3: BLINK, PERIOD=3 -> toggle every 4 cycles
      wr(2'd2, 32'd3);
      chk("period_wr_no_strobe", {31'd0, LedWE}, 32'd0);
      rd("period_readback", 2'd2, 32'd3);
      exp_q.push_back(32'h0000_00FF);
      wr(2'd1, 32'h0000_00FF);
      exp_q.push_back(32'h0000_00FF);
      exp_q.push_back(32'd0);
      exp_q.push_back(32'h0000_00FF);
      exp_q.push_back(32'd0);
      wr(2'd0, 32'd2);                 // sampled at edge E0
      chk("blink_entry", LedData, 32'h0000_00FF);
      idle(3);
      chk("blink_gap", {31'd0, LedWE}, 32'd0);
      idle(1);                         // after E4
      chk("blink_tick1_we", {31'd0, LedWE}, 32'd1);
      chk("blink_tick1_led", LedData, 32'd0);
      idle(11);                        // now just after E15

      // 5: collision - PATTERN write lands on the E16 tick
      exp_q.push_back(32'h0000_000F);
      exp_q.push_back(32'd0);
      wr(2'd1, 32'h0000_000F);
      chk("collide_we", {31'd0, LedWE}, 32'd1);
      chk("collide_led", LedData, 32'h0000_000F);
      idle(1);
      chk("collide_single", {31'd0, LedWE}, 32'd0);
      idle(2);
      chk("collide_gap", {31'd0, LedWE}, 32'd0);
      idle(1);
      chk("collide_next_we", {31'd0, LedWE}, 32'd1);
      chk("collide_next_led", LedData, 32'd0);

      // 4: ROTATE with PERIOD=0
      exp_q.push_back(32'd0);
      wr(2'd0, 32'd0);                 // OFF
      wr(2'd2, 32'd0);
      exp_q.push_back(32'd0);
      wr(2'd1, 32'h8000_0001);         // OFF entry -> 0
      exp_q.push_back(32'h8000_0001);
      exp_q.push_back(32'h0000_0003);
      exp_q.push_back(32'h0000_0006);
      exp_q.push_back(32'h0000_000C);
      wr(2'd0, 32'd3);                 // E0
      idle(3);                         // after E3
      chk("rot_left3", LedData, 32'h0000_000C);
      exp_q.push_back(32'h8000_0001);
      exp_q.push_back(32'hC000_0000);
      wr(2'd0, 32'd7);                 // E4, tick dropped
      idle(1);                         // after E5
      chk("rot_right", LedData, 32'hC000_0000);
      exp_q.push_back(32'd0);
      wr(2'd0, 32'd0);
      idle(5);
      chk("off_quiet", {31'd0, LedWE}, 32'd0);

      // 6: reset mid-ROTATE
      exp_q.push_back(32'h8000_0001);
      exp_q.push_back(32'h0000_0003);
      wr(2'd0, 32'd3);                 // E0
      idle(1);                         // after E1
      reset = 1'b1;
      @(negedge clk);                  // after E2
      chk("midrst_led", LedData, 32'd0);
      chk("midrst_we", {31'd0, LedWE}, 32'd0);
      rd("midrst_ctrl", 2'd0, 32'd0);
      rd("midrst_period", 2'd2, 32'd2500000);
      @(negedge clk);
      reset = 1'b0;
      idle(20);
      chk("post_rst_led", LedData, 32'd0);
      chk("queue_drained", exp_q.size(), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
